naneye_cfg_ctrl: RTL and testbench
==================================

Name: naneye_cfg_ctrl

Overview:
- Configuration-side controller for the NanEye receiver, running in the 48 MHz system clock domain.
- Holds an 8-byte host-writable configuration register bank.
- On a configuration request, reads 24 configuration bits from the bank and serialises them to the sensor as a clock/data/output-enable triplet, then signals completion.
- Drives two active-low break outputs that force the sensor line low during sync-start and configuration windows.

Parameters:
- CLOCK_PERIOD_PS, 20833: system clock period in ps.
- BIT_PERIOD_NS, 400: configuration bit period in ns (2.5 MHz).
- C_NO_CFG_BITS, 24: number of bits sent per transfer; legal range 1..32.
- C_BREAK_CYCLES, 16: length of the sync-start break pulse, in clock cycles.

Ports:
- CLOCK  in  1  system clock; all inputs are synchronous to it.
- RESET_N  in  1  asynchronous, active-low reset.
- WE_A  in  1  host register write strobe.
- ADD_A  in  3  host register byte address.
- DAT_A  in  8  host write data.
- RDAT_A  out  8  host readback of reg[ADD_A], registered.
- CONFIG_EN  in  1  configuration request pulse (START).
- SYNC_START  in  1  decoder sync-start pulse.
- DEC_OUT_EN  in  1  decoder output-valid strobe.
- LINE_PERIOD  in  16  measured line period; 0 = invalid.
- TX_END  out  1  one-cycle done pulse (CONFIG_DONE).
- TX_DAT  out  1  serial configuration data.
- TX_CLK  out  1  serial configuration clock.
- TX_OE  out  1  driver enable for TX_DAT/TX_CLK, active high.
- BREAK_N_OUTPUT  out  2  active-low break drivers.
- BUSY  out  1  high from an accepted CONFIG_EN until TX_END.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - reg[0..7]=8'h00, RDAT_A=0.
  - TX_END=0, TX_DAT=0, TX_CLK=0, TX_OE=0, BUSY=0, BREAK_N_OUTPUT=2'b11.
  - FSM goes to IDLE and all counters clear.
  - Asserting reset mid-transfer aborts the transfer immediately; no TX_END is issued.
- Register bank:
  - WE_A=1 writes DAT_A to reg[ADD_A] on the clock edge.
  - RDAT_A=reg[ADD_A] with 1-cycle latency.
  - An internal 16-bit word read at word address w (2 bits) returns {reg[2w+1], reg[2w]}.
  - Writes during a transfer update the bank but do not alter the bits already loaded.
- Bit timing:
  - BIT_CYC = (BIT_PERIOD_NS*1000)/CLOCK_PERIOD_PS, integer floor; default 19.
  - HALF = BIT_CYC/2, floor; default 9.
- FSM states: IDLE, LOAD0, LOAD1, SHIFT, DONE.
- IDLE:
  - CONFIG_EN=1 with LINE_PERIOD!=0: set BUSY=1 and go to LOAD0.
  - CONFIG_EN=1 with LINE_PERIOD==0: go straight to DONE; nothing is transmitted and TX_OE stays 0.
  - CONFIG_EN while BUSY is ignored.
- LOAD0 / LOAD1:
  - Read word 0, then word 1, one cycle each.
  - Shift register = {word1, word0}; only the low C_NO_CFG_BITS are used.
  - Default transfer bits = {reg[2], reg[1], reg[0]}.
- SHIFT:
  - TX_OE=1 throughout.
  - Bits are sent MSB first, starting at bit C_NO_CFG_BITS-1.
  - Each bit occupies BIT_CYC cycles: TX_CLK=0 for the first HALF cycles, then 1 for the remaining BIT_CYC-HALF cycles.
  - TX_DAT changes only at bit start, i.e. on TX_CLK falling; the sensor samples on TX_CLK rising.
  - After the last bit, go to DONE.
- DONE:
  - TX_END=1 for exactly one cycle.
  - TX_OE=0, TX_CLK=0, TX_DAT=0, BUSY=0, then return to IDLE.
  - A CONFIG_EN arriving in the TX_END cycle is ignored.
- Transfer length: CONFIG_EN to TX_END = 2 + C_NO_CFG_BITS*BIT_CYC + 1 cycles; 459 at defaults.
- Break logic:
  - BREAK_N_OUTPUT[1] = 0 whenever BUSY=1, registered with 1-cycle lag, otherwise 1.
  - SYNC_START=1 loads a counter with C_BREAK_CYCLES; BREAK_N_OUTPUT[0] = 0 while the counter is nonzero.
  - DEC_OUT_EN=1 clears the counter, releasing BREAK_N_OUTPUT[0] on the next cycle.
  - If SYNC_START and DEC_OUT_EN are both 1 in the same cycle, SYNC_START wins.
  - A new SYNC_START during an active break reloads the counter.

Test Plan:
- Reset/readback: with RESET_N low, all outputs hold reset values. After release, write reg[5]=8'hA5; RDAT_A=8'hA5 one cycle after ADD_A=5.
- Basic transfer:
  - Setup: reg0=8'h34, reg1=8'h12, reg2=8'hC3, LINE_PERIOD=16'd1500, CONFIG_EN pulse.
  - Required: TX_DAT bit sequence equals 24'hC31234 MSB first.
  - Required: 24 TX_CLK rising edges, spaced 19 cycles apart; TX_OE high for 456 cycles; TX_END pulse 459 cycles after CONFIG_EN.
- Invalid line period: LINE_PERIOD=0 with a CONFIG_EN pulse → TX_OE stays 0 and TX_END pulses within 2 cycles.
- Busy and mid-transfer writes: a second CONFIG_EN and a write of reg0=8'hFF during SHIFT → the current transfer is unchanged, there is exactly one TX_END, and the next transfer sends 24'hC312FF.
- Break timing:
  - SYNC_START pulse → BREAK_N_OUTPUT[0]=0 for 16 cycles.
  - DEC_OUT_EN at cycle 5 → BREAK_N_OUTPUT[0] released at cycle 6.
  - BREAK_N_OUTPUT[1]=0 throughout BUSY.
- Reset mid-transfer: drop RESET_N during bit 10 → outputs return to reset values immediately and no TX_END is issued; the next CONFIG_EN performs a full transfer.

Source files
------------

// File: rtl/naneye_cfg_ctrl.sv
// rtl/naneye_cfg_ctrl.sv - NanEye configuration register bank, serialiser and break drivers
module naneye_cfg_ctrl #(
    parameter int CLOCK_PERIOD_PS = 20833,
    parameter int BIT_PERIOD_NS   = 400,
    parameter int C_NO_CFG_BITS   = 24,
    parameter int C_BREAK_CYCLES  = 16
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        WE_A,
    input  logic [2:0]  ADD_A,
    input  logic [7:0]  DAT_A,
    output logic [7:0]  RDAT_A,
    input  logic        CONFIG_EN,
    input  logic        SYNC_START,
    input  logic        DEC_OUT_EN,
    input  logic [15:0] LINE_PERIOD,
    output logic        TX_END,
    output logic        TX_DAT,
    output logic        TX_CLK,
    output logic        TX_OE,
    output logic [1:0]  BREAK_N_OUTPUT,
    output logic        BUSY
);

    localparam int BIT_CYC = (BIT_PERIOD_NS * 1000) / CLOCK_PERIOD_PS;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CYC_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BIT_W   = 6;
    localparam int BRK_W   = $clog2(C_BREAK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        sh_q, sh_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [7:0]         regs_q [8];
    logic [7:0]         rdat_q;
    logic [BRK_W-1:0]   brk_cnt_q;
    logic               brk_busy_n_q;
    logic [1:0]         word_addr;
    logic [15:0]        word_rd;

    // Host register bank with registered readback
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
            rdat_q <= 8'h00;
        end else begin
            if (WE_A) begin
                regs_q[ADD_A] <= DAT_A;
            end
            rdat_q <= regs_q[ADD_A];
        end
    end

    assign RDAT_A    = rdat_q;
    assign word_addr = (state_q == S_LOAD1) ? 2'd1 : 2'd0;
    assign word_rd   = {regs_q[{word_addr, 1'b1}], regs_q[{word_addr, 1'b0}]};

    // FSM and serialiser state registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state: load two words, then shift MSB first one bit per BIT_CYC cycles
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (CONFIG_EN) begin
                    state_d = (LINE_PERIOD != 16'd0) ? S_LOAD0 : S_DONE;
                end
            end
            S_LOAD0: begin
                sh_d[15:0] = word_rd;
                state_d    = S_LOAD1;
            end
            S_LOAD1: begin
                sh_d[31:16] = word_rd;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (cyc_q == CYC_W'(BIT_CYC - 1)) begin
                    cyc_d = '0;
                    // Rotate rather than shift so the whole word stays live; only the low bits matter
                    sh_d  = {sh_q[30:0], sh_q[31]};
                    if (bit_q == BIT_W'(C_NO_CFG_BITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BUSY   = (state_q == S_LOAD0) || (state_q == S_LOAD1) || (state_q == S_SHIFT);
    assign TX_OE  = (state_q == S_SHIFT);
    assign TX_END = (state_q == S_DONE);
    assign TX_CLK = TX_OE && (cyc_q >= CYC_W'(HALF));
    assign TX_DAT = TX_OE && sh_q[C_NO_CFG_BITS-1];

    // Break drivers: sync-start pulse counter and busy-window break lagging BUSY by one cycle
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            brk_cnt_q    <= '0;
            brk_busy_n_q <= 1'b1;
        end else begin
            brk_busy_n_q <= ~BUSY;
            if (SYNC_START) begin
                brk_cnt_q <= BRK_W'(C_BREAK_CYCLES);
            end else if (DEC_OUT_EN) begin
                brk_cnt_q <= '0;
            end else if (brk_cnt_q != '0) begin
                brk_cnt_q <= brk_cnt_q - 1'b1;
            end
        end
    end

    assign BREAK_N_OUTPUT = {brk_busy_n_q, (brk_cnt_q == '0)};

endmodule

// File: tb/tb_naneye_cfg_ctrl.sv
// tb/tb_naneye_cfg_ctrl.sv - self-checking bench for naneye_cfg_ctrl
module tb_naneye_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WE_A = 1'b0;
    logic [2:0]  ADD_A = '0;
    logic [7:0]  DAT_A = '0;
    logic [7:0]  RDAT_A;
    logic        CONFIG_EN = 1'b0;
    logic        SYNC_START = 1'b0;
    logic        DEC_OUT_EN = 1'b0;
    logic [15:0] LINE_PERIOD = '0;
    logic        TX_END, TX_DAT, TX_CLK, TX_OE, BUSY;
    logic [1:0]  BREAK_N_OUTPUT;

    naneye_cfg_ctrl dut (
        .CLOCK(clk), .RESET_N(rst_n), .WE_A(WE_A), .ADD_A(ADD_A), .DAT_A(DAT_A),
        .RDAT_A(RDAT_A), .CONFIG_EN(CONFIG_EN), .SYNC_START(SYNC_START),
        .DEC_OUT_EN(DEC_OUT_EN), .LINE_PERIOD(LINE_PERIOD), .TX_END(TX_END),
        .TX_DAT(TX_DAT), .TX_CLK(TX_CLK), .TX_OE(TX_OE),
        .BREAK_N_OUTPUT(BREAK_N_OUTPUT), .BUSY(BUSY)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          nbits;
        int          start;
    } xfer_t;
    xfer_t sb_q[$];

    typedef struct { logic we; logic [2:0] add; logic [7:0] dat; logic [7:0] rd; } rv_t;
    typedef struct { logic [7:0] r0, r1, r2; logic [15:0] lp; logic [31:0] data; int nb; } xv_t;
    typedef struct { int dec_at; int sync2_at; int low; int rel; } bv_t;
    rv_t rv [8];
    xv_t xv [4];
    bv_t bv [4];

    // Monitor: collect bits on TX_CLK rising, score each TX_END against the queue
    logic        prev_clk = 0, prev_oe = 0, prev_dat = 0, prev_busy = 0;
    int          rx_cnt = 0, oe_cnt = 0, last_rise = 0, end_cnt = 0;
    logic [31:0] rx_sh = '0;
    xfer_t       e;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_cnt = 0; oe_cnt = 0; rx_sh = '0;
            prev_clk = 0; prev_oe = 0; prev_dat = 0; prev_busy = 0;
        end else begin
            chk("break1_lag", {31'd0, BREAK_N_OUTPUT[1]}, {31'd0, !prev_busy});
            if (TX_OE) oe_cnt++;
            if (TX_CLK && !prev_clk) begin
                if (rx_cnt > 0) chk("clk_spacing", cyc - last_rise, 19);
                last_rise = cyc;
                rx_sh = {rx_sh[30:0], TX_DAT};
                rx_cnt++;
            end
            if (TX_OE && prev_oe && (TX_DAT !== prev_dat))
                chk("dat_change_at_fall", {30'd0, prev_clk, TX_CLK}, 32'd2);
            if (TX_END) begin
                end_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_tx_end", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("tx_data", rx_sh, e.data);
                    chk("tx_bits", rx_cnt, e.nbits);
                    chk("tx_oe_cycles", oe_cnt, e.nbits * 19);
                    chk("tx_latency", cyc - e.start, (e.nbits == 0) ? 1 : 2 + e.nbits * 19 + 1);
                    chk("tx_oe_at_end", {31'd0, TX_OE}, 0);
                end
                rx_cnt = 0; oe_cnt = 0; rx_sh = '0;
            end
            prev_clk = TX_CLK; prev_oe = TX_OE; prev_dat = TX_DAT; prev_busy = BUSY;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WE_A = 1; ADD_A = a; DAT_A = d;
        tick(1);
        WE_A = 0;
    endtask

    task automatic start_xfer(input logic [31:0] d, input int nb, input bit push);
        xfer_t x;
        CONFIG_EN = 1;
        if (push) begin
            x.data = d; x.nbits = nb; x.start = cyc;
            sb_q.push_back(x);
        end
        tick(1);
        CONFIG_EN = 0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin tick(1); n++; end
        chk("xfer_timeout", sb_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdat"}, RDAT_A, 0);
        chk({tag, "_tx_end"}, {31'd0, TX_END}, 0);
        chk({tag, "_tx_dat"}, {31'd0, TX_DAT}, 0);
        chk({tag, "_tx_clk"}, {31'd0, TX_CLK}, 0);
        chk({tag, "_tx_oe"}, {31'd0, TX_OE}, 0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 0);
        chk({tag, "_break"}, {30'd0, BREAK_N_OUTPUT}, 3);
    endtask

    initial begin
        int e0, low, last_low;
        rv[0] = '{1'b1, 3'd5, 8'hA5, 8'h00};
        rv[1] = '{1'b0, 3'd5, 8'h00, 8'hA5};
        rv[2] = '{1'b1, 3'd3, 8'h77, 8'h00};
        rv[3] = '{1'b0, 3'd3, 8'h00, 8'h77};
        rv[4] = '{1'b0, 3'd4, 8'h00, 8'h00};
        rv[5] = '{1'b1, 3'd7, 8'hFF, 8'h00};
        rv[6] = '{1'b0, 3'd7, 8'h00, 8'hFF};
        rv[7] = '{1'b0, 3'd5, 8'h00, 8'hA5};
        xv[0] = '{8'h34, 8'h12, 8'hC3, 16'd1500, 32'hC31234, 24};
        xv[1] = '{8'h00, 8'h00, 8'h00, 16'd0,    32'h0,      0};
        xv[2] = '{8'hFF, 8'h00, 8'hAA, 16'd1,    32'hAA00FF, 24};
        xv[3] = '{8'h5A, 8'hA5, 8'h3C, 16'hFFFF, 32'h3CA55A, 24};
        bv[0] = '{-1, -1, 16, 17};
        bv[1] = '{5,  -1, 5,  6};
        bv[2] = '{0,  -1, 16, 17};
        bv[3] = '{-1, 10, 26, 27};

        tick(3);
        chk_reset_outputs("reset");
        rst_n = 1;
        tick(1);

        foreach (rv[i]) begin
            if (rv[i].we) begin
                wr(rv[i].add, rv[i].dat);
            end else begin
                ADD_A = rv[i].add;
                tick(1);
                chk("rdat", RDAT_A, rv[i].rd);
            end
        end

        foreach (xv[i]) begin
            wr(3'd0, xv[i].r0); wr(3'd1, xv[i].r1); wr(3'd2, xv[i].r2);
            LINE_PERIOD = xv[i].lp;
            start_xfer(xv[i].data, xv[i].nb, 1'b1);
            wait_drain(600);
        end

        // Busy: second CONFIG_EN plus reg0 write in mid-shift
        wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd2, 8'hC3);
        LINE_PERIOD = 16'd1500;
        e0 = end_cnt;
        start_xfer(32'hC31234, 24, 1'b1);
        tick(100);
        chk("busy_mid", {31'd0, BUSY}, 1);
        chk("break1_mid", {31'd0, BREAK_N_OUTPUT[1]}, 0);
        CONFIG_EN = 1; WE_A = 1; ADD_A = 3'd0; DAT_A = 8'hFF;
        tick(1);
        CONFIG_EN = 0; WE_A = 0;
        wait_drain(600);
        tick(20);
        chk("one_tx_end", end_cnt - e0, 1);
        start_xfer(32'hC312FF, 24, 1'b1);
        wait_drain(600);

        // Invalid line period, then CONFIG_EN in the TX_END cycle is dropped
        LINE_PERIOD = 16'd0;
        start_xfer(32'h0, 0, 1'b1);
        chk("tx_end_fast", {31'd0, TX_END}, 1);
        chk("invalid_oe", {31'd0, TX_OE}, 0);
        LINE_PERIOD = 16'd1500;
        e0 = end_cnt;
        CONFIG_EN = 1;
        tick(1);
        CONFIG_EN = 0;
        chk("done_cfg_ignored", {31'd0, BUSY}, 0);
        tick(3);
        chk("done_cfg_ignored2", {31'd0, BUSY}, 0);
        chk("done_cfg_no_end", end_cnt - e0, 1);

        foreach (bv[k]) begin
            low = 0; last_low = -1;
            for (int i = 0; i < 32; i++) begin
                SYNC_START = (i == 0) || (i == bv[k].sync2_at);
                DEC_OUT_EN = (i == bv[k].dec_at);
                @(negedge clk);
                if (!BREAK_N_OUTPUT[0]) begin low++; last_low = i; end
                @(posedge clk); #1;
            end
            SYNC_START = 0; DEC_OUT_EN = 0;
            chk("break0_low", low, bv[k].low);
            chk("break0_release", last_low + 1, bv[k].rel);
        end

        // Reset during bit 10 aborts the transfer with no TX_END
        start_xfer(32'h0, 24, 1'b0);
        tick(200);
        chk("pre_reset_oe", {31'd0, TX_OE}, 1);
        e0 = end_cnt;
        rst_n = 0;
        #1;
        chk_reset_outputs("midreset");
        tick(2);
        rst_n = 1;
        tick(480);
        chk("no_end_after_reset", end_cnt - e0, 0);
        wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd2, 8'hC3);
        start_xfer(32'hC31234, 24, 1'b1);
        wait_drain(600);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
